// File: rtl/arm_mem_pkg.sv
// Shared definitions for the arm6 data-memory path: bridge state encoding,
// byte-lane constants and the request legality check.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ABORT  = 2'd3
    } state_t;

    localparam logic [3:0] FLAG_NONE    = 4'h0;
    localparam logic [3:0] FLAG_WORD    = 4'hF;
    localparam logic [3:0] FLAG_HALF_LO = 4'h3;
    localparam logic [3:0] FLAG_HALF_HI = 4'hC;

    // True when the request falls outside the SRAM window or its lanes do not
    // match the address alignment (words on 4-byte, halfwords on 2-byte).
    function automatic logic access_bad(
        input logic [31:0] addr,
        input logic [3:0]  flag,
        input logic [31:0] base,
        input int          aw
    );
        logic w_in_range;
        logic w_misaligned;
        w_in_range   = (addr >> (aw + 2)) == (base >> (aw + 2));
        w_misaligned = ((flag == FLAG_WORD) && (addr[1:0] != 2'b00)) ||
                       (((flag == FLAG_HALF_LO) || (flag == FLAG_HALF_HI)) && addr[0]);
        return !w_in_range || (flag == FLAG_NONE) || w_misaligned;
    endfunction

endpackage

// File: rtl/ram_addr_chk.sv
// Combinational legality check of a core data request against the SRAM window.
module ram_addr_chk
    import arm_mem_pkg::*;
#(
    parameter logic [31:0] RAM_BASE = 32'h0000_0000,
    parameter int          RAM_AW   = 12
) (
    input  logic [31:0] addr,
    input  logic [3:0]  flag,
    output logic        bad
);

    assign bad = access_bad(addr, flag, RAM_BASE, RAM_AW);

endmodule

// File: rtl/ram_bridge.sv
// Bridge from the arm6 core data port to a wait-stated single-port word SRAM;
// stalls the core while an access is in flight and flags illegal requests.
module ram_bridge
    import arm_mem_pkg::*;
#(
    parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
    parameter int          RAM_AW      = 12,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ram_addr,
    input  logic              ram_cen,
    input  logic              ram_wen,
    input  logic [3:0]        ram_flag,
    input  logic [31:0]       ram_wdata,
    output logic [31:0]       ram_rdata,
    output logic              ram_abort,
    output logic              cpu_en,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [3:0]        sram_be,
    output logic [RAM_AW-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    localparam int              CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_we;
    logic [3:0]         r_be;
    logic [RAM_AW-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;

    logic               w_bad;
    logic               w_last;
    logic               w_cpu_en;
    logic               w_cs;
    logic               w_abort;

    ram_addr_chk #(
        .RAM_BASE (RAM_BASE),
        .RAM_AW   (RAM_AW)
    ) u_addr_chk (
        .addr (ram_addr),
        .flag (ram_flag),
        .bad  (w_bad)
    );

    assign w_last = (r_cnt == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_cpu_en     = 1'b1;
        w_cs         = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                w_cpu_en = !ram_cen;
                if (ram_cen) begin
                    w_next_state = w_bad ? ABORT : ACCESS;
                end
            end
            ACCESS: begin
                w_cpu_en = 1'b0;
                w_cs     = 1'b1;
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            ABORT: begin
                w_abort      = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Request fields are latched once on acceptance so the SRAM sees stable
    // controls for the whole access even though the core holds them anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_be    <= 4'h0;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ram_cen && !w_bad) begin
                        r_addr  <= ram_addr[RAM_AW+1:2];
                        r_we    <= ram_wen;
                        r_be    <= ram_flag;
                        r_wdata <= ram_wdata;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                ACCESS: begin
                    if (!w_last) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (!r_we) begin
                        r_rdata <= sram_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Reset forces IDLE asynchronously, which drops sram_cs at once; the
    // core is released during reset so it never deadlocks on a stall.
    assign cpu_en     = rst | w_cpu_en;
    assign sram_cs    = w_cs;
    assign sram_we    = w_cs & r_we;
    assign sram_be    = r_be;
    assign sram_addr  = r_addr;
    assign sram_wdata = r_wdata;
    assign ram_abort  = w_abort;
    assign ram_rdata  = w_abort ? 32'h0 : r_rdata;

endmodule

// File: tb/tb_ram_bridge.sv
// Randomised bench for ram_bridge: two instances (WAIT_CYCLES 1 and 0) against
// a word-memory model of the core's view and a simple SRAM responder.
module tb_ram_bridge;

    localparam int AW    = 12;
    localparam int WORDS = 4096;

    logic clk = 1'b0;
    logic rst;

    logic [31:0]   ram_addr   [2];
    logic          ram_cen    [2];
    logic          ram_wen    [2];
    logic [3:0]    ram_flag   [2];
    logic [31:0]   ram_wdata  [2];
    logic [31:0]   ram_rdata  [2];
    logic          ram_abort  [2];
    logic          cpu_en     [2];
    logic          sram_cs    [2];
    logic          sram_we    [2];
    logic [3:0]    sram_be    [2];
    logic [AW-1:0] sram_addr  [2];
    logic [31:0]   sram_wdata [2];
    logic [31:0]   sram_rdata [2];

    bit [31:0]   sram_mem [2][WORDS];
    bit [31:0]   ref_mem  [2][WORDS];
    logic [31:0] prev_rd  [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ram_bridge #(.RAM_BASE(32'h0), .RAM_AW(AW), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .rst(rst),
        .ram_addr(ram_addr[0]), .ram_cen(ram_cen[0]), .ram_wen(ram_wen[0]),
        .ram_flag(ram_flag[0]), .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0]),
        .ram_abort(ram_abort[0]), .cpu_en(cpu_en[0]),
        .sram_cs(sram_cs[0]), .sram_we(sram_we[0]), .sram_be(sram_be[0]),
        .sram_addr(sram_addr[0]), .sram_wdata(sram_wdata[0]), .sram_rdata(sram_rdata[0])
    );

    ram_bridge #(.RAM_BASE(32'h0), .RAM_AW(AW), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst(rst),
        .ram_addr(ram_addr[1]), .ram_cen(ram_cen[1]), .ram_wen(ram_wen[1]),
        .ram_flag(ram_flag[1]), .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1]),
        .ram_abort(ram_abort[1]), .cpu_en(cpu_en[1]),
        .sram_cs(sram_cs[1]), .sram_we(sram_we[1]), .sram_be(sram_be[1]),
        .sram_addr(sram_addr[1]), .sram_wdata(sram_wdata[1]), .sram_rdata(sram_rdata[1])
    );

    // SRAM responder: asynchronous read, byte-enabled write on the clock edge.
    assign sram_rdata[0] = sram_mem[0][sram_addr[0]];
    assign sram_rdata[1] = sram_mem[1][sram_addr[1]];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (sram_cs[d] && sram_we[d]) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_be[d][b]) sram_mem[d][sram_addr[d]][8*b +: 8] <= sram_wdata[d][8*b +: 8];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int wait_of(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    // Core-view legality: the window is bytes 0..16383; words need 4-byte,
    // halfwords 2-byte alignment; no lanes is illegal.
    function automatic bit exp_bad(input logic [31:0] a, input logic [3:0] f);
        bit in_range;
        in_range = (a < 32'd16384);
        if (!in_range || f == 4'h0) return 1'b1;
        if (f == 4'hF && (a % 4) != 0) return 1'b1;
        if ((f == 4'h3 || f == 4'hC) && (a % 2) != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            ram_cen[0] = 1'b0;
            ram_cen[1] = 1'b0;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check($sformatf("d%0d idle cpu_en", d), 32'(cpu_en[d]), 32'd1);
                check($sformatf("d%0d idle abort", d), 32'(ram_abort[d]), 32'd0);
                check($sformatf("d%0d idle cs", d), 32'(sram_cs[d]), 32'd0);
            end
        end
    endtask

    // One core request from presentation through the cycle cpu_en returns to 1.
    task automatic do_txn(input int d, input logic [31:0] a, input logic w,
                          input logic [3:0] f, input logic [31:0] wd);
        bit          bad;
        int          exp_lat;
        int          cyc;
        int          cs_cnt;
        bit          done;
        int          idx;
        logic [31:0] exp_rd;
        bad     = exp_bad(a, f);
        exp_lat = bad ? 1 : wait_of(d) + 2;
        idx     = (a % 16384) / 4;

        @(posedge clk); #1;
        ram_cen[1-d]  = 1'b0;
        ram_cen[d]    = 1'b1;
        ram_addr[d]   = a;
        ram_wen[d]    = w;
        ram_flag[d]   = f;
        ram_wdata[d]  = wd;
        @(negedge clk);
        check($sformatf("d%0d first-cycle stall", d), 32'(cpu_en[d]), 32'd0);
        check($sformatf("d%0d first-cycle cs", d), 32'(sram_cs[d]), 32'd0);

        cyc    = 0;
        cs_cnt = 0;
        done   = 1'b0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (sram_cs[d]) begin
                cs_cnt++;
                check($sformatf("d%0d sram_addr", d), 32'(sram_addr[d]), 32'(idx));
                check($sformatf("d%0d sram_be", d), 32'(sram_be[d]), 32'(f));
                check($sformatf("d%0d sram_we", d), 32'(sram_we[d]), 32'(w));
                if (w) check($sformatf("d%0d sram_wdata", d), sram_wdata[d], wd);
            end
            if (cpu_en[d]) begin
                done = 1'b1;
            end else begin
                check($sformatf("d%0d rdata hold", d), ram_rdata[d], prev_rd[d]);
                check($sformatf("d%0d early abort", d), 32'(ram_abort[d]), 32'd0);
            end
        end
        check($sformatf("d%0d latency", d), 32'(cyc), 32'(exp_lat));
        check($sformatf("d%0d cs cycles", d), 32'(cs_cnt), bad ? 32'd0 : 32'(wait_of(d) + 1));
        check($sformatf("d%0d abort", d), 32'(ram_abort[d]), 32'(bad));

        if (bad) begin
            exp_rd = 32'h0;
        end else if (!w) begin
            exp_rd     = ref_mem[d][idx];
            prev_rd[d] = exp_rd;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (f[b]) ref_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
            end
            exp_rd = prev_rd[d];
        end
        check($sformatf("d%0d rdata", d), ram_rdata[d], exp_rd);
    endtask

    logic [3:0] flag_tab [10];

    initial begin
        flag_tab = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h5, 4'hF};
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            ram_addr[d]  = 32'h0;
            ram_cen[d]   = 1'b0;
            ram_wen[d]   = 1'b0;
            ram_flag[d]  = 4'h0;
            ram_wdata[d] = 32'h0;
            prev_rd[d]   = 32'h0;
        end
        ram_cen[0] = 1'b1;
        #2;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d rst cpu_en", d), 32'(cpu_en[d]), 32'd1);
            check($sformatf("d%0d rst cs", d), 32'(sram_cs[d]), 32'd0);
            check($sformatf("d%0d rst we", d), 32'(sram_we[d]), 32'd0);
            check($sformatf("d%0d rst be", d), 32'(sram_be[d]), 32'd0);
            check($sformatf("d%0d rst addr", d), 32'(sram_addr[d]), 32'd0);
            check($sformatf("d%0d rst wdata", d), sram_wdata[d], 32'd0);
            check($sformatf("d%0d rst rdata", d), ram_rdata[d], 32'd0);
            check($sformatf("d%0d rst abort", d), 32'(ram_abort[d]), 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        ram_cen[0] = 1'b0;
        rst        = 1'b0;
        idle(2);

        // Directed cases on the WAIT_CYCLES=1 instance.
        do_txn(0, 32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF);
        do_txn(0, 32'h10, 1'b0, 4'hF, 32'h0);
        do_txn(0, 32'h0000_4000, 1'b0, 4'hF, 32'h0);
        idle(1);
        do_txn(0, 32'h12, 1'b1, 4'hF, 32'h1234_5678);
        do_txn(0, 32'h13, 1'b1, 4'h8, 32'hA5A5_A5A5);
        do_txn(0, 32'h10, 1'b0, 4'hF, 32'h0);
        do_txn(0, 32'h3FFC, 1'b1, 4'hF, 32'hCAFE_F00D);
        do_txn(0, 32'h3FFE, 1'b0, 4'hC, 32'h0);
        do_txn(0, 32'h11, 1'b0, 4'h3, 32'h0);
        idle(2);

        // Zero-wait instance: write, then two back-to-back reads.
        do_txn(1, 32'h10, 1'b1, 4'hF, 32'h0BAD_CAFE);
        idle(1);
        do_txn(1, 32'h10, 1'b0, 4'hF, 32'h0);
        do_txn(1, 32'h10, 1'b0, 4'h1, 32'h0);
        idle(1);

        // Reset in the middle of a write access; data equals current contents.
        @(posedge clk); #1;
        ram_cen[1]   = 1'b0;
        ram_cen[0]   = 1'b1;
        ram_addr[0]  = 32'h20;
        ram_wen[0]   = 1'b1;
        ram_flag[0]  = 4'hF;
        ram_wdata[0] = ref_mem[0][8];
        @(posedge clk); #1;
        check("rst-mid pre cs", 32'(sram_cs[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst-mid cs", 32'(sram_cs[0]), 32'd0);
        check("rst-mid cpu_en", 32'(cpu_en[0]), 32'd1);
        check("rst-mid abort", 32'(ram_abort[0]), 32'd0);
        check("rst-mid rdata", ram_rdata[0], 32'd0);
        @(negedge clk);
        ram_cen[0] = 1'b0;
        @(negedge clk);
        rst        = 1'b0;
        prev_rd[0] = 32'h0;
        prev_rd[1] = 32'h0;
        idle(3);
        do_txn(0, 32'h20, 1'b0, 4'hF, 32'h0);
        do_txn(0, 32'h10, 1'b0, 4'hF, 32'h0);

        // Randomised traffic on both instances.
        for (int i = 0; i < 300; i++) begin
            int          d;
            logic [31:0] a;
            logic [3:0]  f;
            d = int'($urandom_range(0, 1));
            f = flag_tab[$urandom_range(0, 9)];
            case ($urandom_range(0, 9))
                0:       a = 32'h4000 + 32'($urandom_range(0, 7));
                1:       a = $urandom | 32'h8000_0000;
                2:       a = 32'h3FF8 + 32'($urandom_range(0, 7));
                default: a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
            do_txn(d, a, 1'($urandom_range(0, 1)), f, $urandom);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
